// File: rtl/stack_arb_pkg.sv
// rtl/stack_arb_pkg.sv - shared types and constants for the arbitrated stack
package stack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;
    localparam int   NUM_REQ = 2;

endpackage

// File: rtl/stack_arb_mem.sv
// rtl/stack_arb_mem.sv - stack storage, one synchronous write port and one registered read port
module stack_arb_mem
    import stack_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester arbitrated push/pop stack; STACK_ARB_ROUND_ROBIN_EN selects round-robin ties
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         op,
    input  logic [WIDTH-1:0]           wdata0,
    input  logic [WIDTH-1:0]           wdata1,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           rdata,
    output logic                       err,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    state_e                state_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    done_q;
    logic                  err_q;
    logic                  rd_valid_q;
    logic [CW-1:0]         count_q;
    logic                  op_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  win_d;
    logic                  full_d;
    logic                  empty_d;
    logic                  push_ok;
    logic                  pop_ok;
    logic [WIDTH-1:0]      mem_rdata;

`ifdef STACK_ARB_ROUND_ROBIN_EN
    logic last_q;

    // On a tie the requester not served last wins; pointer 0 favours requester 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b0;
        end else if (state_q == IDLE && |req) begin
            last_q <= win_d;
        end
    end

    always_comb begin
        win_d = (req == 2'b11) ? ~last_q : ~req[0];
    end
`else
    assign win_d = ~req[0];
`endif

    assign full_d  = (count_q == CNT_FULL);
    assign empty_d = (count_q == '0);
    assign push_ok = (op_q == OP_PUSH) && !full_d;
    assign pop_ok  = (op_q == OP_POP) && !empty_d;

    stack_arb_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (state_q == EXEC && push_ok && !reset),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (wdata_q),
        .re_i    (state_q == EXEC && pop_ok),
        .raddr_i (AW'(count_q - CNT_ONE)),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            count_q    <= '0;
            op_q       <= OP_PUSH;
            wdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q     <= '0;
                    err_q      <= 1'b0;
                    rd_valid_q <= 1'b0;
                    gnt_q      <= '0;
                    if (|req) begin
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        op_q    <= op[win_d];
                        wdata_q <= win_d ? wdata1 : wdata0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    done_q  <= gnt_q;
                    state_q <= RESP;
                    if (op_q == OP_PUSH) begin
                        rd_valid_q <= 1'b0;
                        err_q      <= full_d;
                        if (push_ok) begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end else begin
                        rd_valid_q <= pop_ok;
                        err_q      <= empty_d;
                        if (pop_ok) begin
                            count_q <= count_q - CNT_ONE;
                        end
                    end
                end
                RESP: begin
                    done_q     <= '0;
                    gnt_q      <= '0;
                    err_q      <= 1'b0;
                    rd_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is exposed only for a successful pop, so pushes and underflows return zero.
    assign rdata = rd_valid_q ? mem_rdata : '0;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign count = count_q;
    assign full  = full_d;
    assign empty = empty_d;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - self-checking bench for stack_arbiter with a transaction-level stack model
module tb_stack_arbiter;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       op;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    stack_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .op     (op),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt    (gnt),
        .done   (done),
        .rdata  (rdata),
        .err    (err),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Transaction-level model: a transaction accepted at cycle start grants for two cycles,
    // applies its stack effect one cycle later and pulses done in that second cycle.
    int               cyc = 0;
    int               start = 0;
    bit               busy = 1'b0;
    int               win = 0;
    bit               mop = 1'b0;
    logic [WIDTH-1:0] mwd = '0;
    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_rdata = '0;
    bit               m_err = 1'b0;
    bit               m_rst = 1'b0;
    bit               chk_en = 1'b0;
`ifdef STACK_ARB_ROUND_ROBIN_EN
    bit               ptr = 1'b0;
`endif

    always @(posedge clk) begin
        cyc++;
        m_rst = reset;
        if (reset) begin
            busy = 1'b0;
            stk.delete();
            chk_en = 1'b1;
`ifdef STACK_ARB_ROUND_ROBIN_EN
            ptr = 1'b0;
`endif
        end else if (busy) begin
            if (cyc - start == 1) begin
                m_rdata = '0;
                m_err = 1'b0;
                if (mop == 1'b0) begin
                    if (stk.size() == DEPTH) m_err = 1'b1;
                    else stk.push_back(mwd);
                end else begin
                    if (stk.size() == 0) m_err = 1'b1;
                    else m_rdata = stk.pop_back();
                end
            end else begin
                busy = 1'b0;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) begin
`ifdef STACK_ARB_ROUND_ROBIN_EN
                win = ptr ? 0 : 1;
`else
                win = 0;
`endif
            end else begin
                win = req[0] ? 0 : 1;
            end
`ifdef STACK_ARB_ROUND_ROBIN_EN
            ptr = (win == 1);
`endif
            busy = 1'b1;
            start = cyc;
            mop = op[win];
            mwd = (win == 1) ? wdata1 : wdata0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [1:0] eg;
        logic [1:0] ed;
        if (chk_en) begin
            eg = busy ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            ed = (busy && cyc == start + 1) ? eg : 2'b00;
            chk("gnt", 32'(gnt), 32'(eg));
            chk("done", 32'(done), 32'(ed));
            chk("count", 32'(count), 32'(stk.size()));
            chk("full", 32'(full), 32'(stk.size() == DEPTH));
            chk("empty", 32'(empty), 32'(stk.size() == 0));
            if (ed != 2'b00) begin
                chk("rdata", 32'(rdata), 32'(m_rdata));
                chk("err", 32'(err), 32'(m_err));
            end
            if (m_rst) begin
                chk("rst_rdata", 32'(rdata), 32'h0);
                chk("rst_err", 32'(err), 32'h0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction from requester r; returns gnt one cycle after sampling and the done-cycle outputs.
    task automatic txn(input int r, input logic o, input logic [WIDTH-1:0] d,
                       output logic [1:0] g1, output logic [1:0] dn,
                       output logic [WIDTH-1:0] rd, output logic e);
        int n;
        @(negedge clk);
        req = (r == 1) ? 2'b10 : 2'b01;
        op[r] = o;
        if (r == 1) wdata1 = d;
        else wdata0 = d;
        @(negedge clk);
        g1 = gnt;
        n = 0;
        while (done == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", 32'(n), 32'd1);
        dn = done;
        rd = rdata;
        e = err;
        req = 2'b00;
    endtask

    logic [1:0]       g1;
    logic [1:0]       dn;
    logic [WIDTH-1:0] rd;
    logic             e;
    logic [1:0]       seq [4];
    logic [1:0]       exp_seq [4];

    initial begin
        reset = 1'b1;
        req = 2'b00;
        op = 2'b00;
        wdata0 = '0;
        wdata1 = '0;

        do_reset();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // single push
        txn(0, 1'b0, 8'hA5, g1, dn, rd, e);
        chk("push_gnt", 32'(g1), 32'h1);
        chk("push_done", 32'(dn), 32'h1);
        chk("push_err", 32'(e), 32'h0);
        chk("push_count", 32'(count), 32'd1);

        // LIFO order across requesters
        do_reset();
        txn(1, 1'b0, 8'h11, g1, dn, rd, e);
        txn(1, 1'b0, 8'h22, g1, dn, rd, e);
        txn(0, 1'b1, 8'h00, g1, dn, rd, e);
        chk("lifo_done", 32'(dn), 32'h1);
        chk("lifo_rdata", 32'(rd), 32'h22);
        chk("lifo_count", 32'(count), 32'd1);

        // underflow
        do_reset();
        txn(1, 1'b1, 8'h00, g1, dn, rd, e);
        chk("uflow_done", 32'(dn), 32'h2);
        chk("uflow_err", 32'(e), 32'h1);
        chk("uflow_rdata", 32'(rd), 32'h0);
        chk("uflow_count", 32'(count), 32'd0);
        chk("uflow_empty", 32'(empty), 32'd1);

        // overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            txn(0, 1'b0, 8'(8'h30 + i), g1, dn, rd, e);
        end
        txn(0, 1'b0, 8'h77, g1, dn, rd, e);
        chk("oflow_err", 32'(e), 32'h1);
        chk("oflow_count", 32'(count), 32'd16);
        chk("oflow_full", 32'(full), 32'd1);
        txn(1, 1'b1, 8'h00, g1, dn, rd, e);
        chk("oflow_pop_rdata", 32'(rd), 32'h3F);
        chk("oflow_pop_err", 32'(e), 32'h0);

        // contention: both hold req for four transactions
        do_reset();
        @(negedge clk);
        req = 2'b11;
        op = 2'b00;
        wdata0 = 8'hC0;
        wdata1 = 8'hC1;
        begin : tie
            int k;
            int n;
            k = 0;
            n = 0;
            while (k < 4 && n < 40) begin
                @(negedge clk);
                n++;
                if (done != 2'b00) begin
                    seq[k] = done;
                    k++;
                    if (k == 4) req = 2'b00;
                end
            end
            chk("tie_count", 32'(k), 32'd4);
        end
`ifdef STACK_ARB_ROUND_ROBIN_EN
        exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int i = 0; i < 4; i++) begin
            chk("tie_gnt", 32'(seq[i]), 32'(exp_seq[i]));
        end

        // reset in the EXEC cycle of a pop aborts it
        do_reset();
        txn(0, 1'b0, 8'h55, g1, dn, rd, e);
        @(negedge clk);
        req = 2'b01;
        op[0] = 1'b1;
        @(negedge clk);
        chk("abort_exec_gnt", 32'(gnt), 32'h1);
        reset = 1'b1;
        req = 2'b00;
        @(negedge clk);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_count", 32'(count), 32'd0);
        reset = 1'b0;
        txn(1, 1'b0, 8'h66, g1, dn, rd, e);
        chk("after_abort_done", 32'(dn), 32'h2);
        chk("after_abort_err", 32'(e), 32'h0);
        chk("after_abort_count", 32'(count), 32'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
